branch_perf_monitor: RTL

//  Counts branch-predictor events in the MIPS pipeline: branches, flushes, skip

---
 rtl/branch_perf_monitor.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/branch_perf_monitor.sv
// Branch-predictor event counters with a halt-triggered serial divider that
// turns the frozen counts into integer success percentages.
module branch_perf_monitor #(
    parameter int CNT_W = 32,
    parameter int PCT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch_valid,
    input  logic             flush,
    input  logic             skip_en,
    input  logic             skip_flush,
    input  logic             halt,
    output logic             halt_rise,
    output logic [CNT_W-1:0] branch_inst_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] skip_en_cnt,
    output logic [CNT_W-1:0] skip_flush_cnt,
    output logic [PCT_W-1:0] rate_all,
    output logic [PCT_W-1:0] rate_skip,
    output logic             rate_valid,
    output logic [1:0]       div0,
    output logic             busy
);

    // Dividend is count*100, which needs 7 extra bits over the counter width.
    localparam int NUM_W  = CNT_W + 7;
    localparam int STEP_W = $clog2(NUM_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_W - 1);

    typedef enum logic [1:0] {IDLE, DIV_ALL, DIV_SKIP, DONE} state_t;

    state_t            state_q;
    logic              halt_q, halt_rise_q, frozen_q;
    logic [CNT_W-1:0]  branch_cnt_q, flush_cnt_q, skip_cnt_q, skip_flush_cnt_q;
    logic [PCT_W-1:0]  rate_all_q, rate_skip_q;
    logic              rate_valid_q, busy_q;
    logic [1:0]        div0_q;
    logic [STEP_W-1:0] step_q;
    logic [CNT_W-1:0]  rem_q, dvsr_q;
    logic [NUM_W-1:0]  dq_q;

    logic              cnt_en;
    logic [CNT_W-1:0]  good_all, good_skip;
    logic [NUM_W-1:0]  num_all, num_skip;
    logic [CNT_W:0]    rem_sh, rem_sub;
    logic              q_bit;
    logic [CNT_W-1:0]  rem_d;
    logic [NUM_W-1:0]  dq_d;

    // Events in the halt_rise cycle are dropped; after it the counts are frozen.
    assign cnt_en = ~frozen_q & ~halt_rise_q;

    // Successful predictions, clamped at zero when flushes outnumber branches.
    assign good_all  = (branch_cnt_q > flush_cnt_q) ? branch_cnt_q - flush_cnt_q : '0;
    assign good_skip = (skip_cnt_q > skip_flush_cnt_q) ? skip_cnt_q - skip_flush_cnt_q : '0;
    assign num_all   = NUM_W'(good_all)  * NUM_W'(100);
    assign num_skip  = NUM_W'(good_skip) * NUM_W'(100);

    // One restoring-divide step: dividend bits shift out of dq_q's top while
    // quotient bits shift in at the bottom.
    always_comb begin
        rem_sh  = {rem_q, dq_q[NUM_W-1]};
        rem_sub = rem_sh - {1'b0, dvsr_q};
        q_bit   = (rem_sh >= {1'b0, dvsr_q});
        rem_d   = q_bit ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
        dq_d    = {dq_q[NUM_W-2:0], q_bit};
    end

    // Halt edge detector and the sticky freeze flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_q      <= 1'b0;
            halt_rise_q <= 1'b0;
            frozen_q    <= 1'b0;
        end else begin
            halt_q      <= halt;
            halt_rise_q <= halt & ~halt_q;
            frozen_q    <= frozen_q | halt_rise_q;
        end
    end

    // Four independent saturating event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt_q     <= '0;
            flush_cnt_q      <= '0;
            skip_cnt_q       <= '0;
            skip_flush_cnt_q <= '0;
        end else if (cnt_en) begin
            if (branch_valid && branch_cnt_q != CNT_MAX)
                branch_cnt_q <= branch_cnt_q + 1'b1;
            if (flush && flush_cnt_q != CNT_MAX)
                flush_cnt_q <= flush_cnt_q + 1'b1;
            if (skip_en && skip_cnt_q != CNT_MAX)
                skip_cnt_q <= skip_cnt_q + 1'b1;
            if (skip_flush && skip_flush_cnt_q != CNT_MAX)
                skip_flush_cnt_q <= skip_flush_cnt_q + 1'b1;
        end
    end

    // Rate FSM: two fixed-length divides back to back. A zero divisor still
    // runs the full step count so latency never depends on the data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            rate_valid_q <= 1'b0;
            rate_all_q   <= '0;
            rate_skip_q  <= '0;
            div0_q       <= 2'b00;
            step_q       <= '0;
            rem_q        <= '0;
            dvsr_q       <= '0;
            dq_q         <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (halt_rise_q) begin
                        state_q      <= DIV_ALL;
                        busy_q       <= 1'b1;
                        rate_valid_q <= 1'b0;
                        step_q       <= '0;
                        rem_q        <= '0;
                        dq_q         <= num_all;
                        dvsr_q       <= branch_cnt_q;
                    end
                end
                DIV_ALL: begin
                    rem_q  <= rem_d;
                    dq_q   <= dq_d;
                    step_q <= step_q + 1'b1;
                    if (step_q == STEP_LAST) begin
                        rate_all_q <= (dvsr_q == '0) ? '0 : dq_d[PCT_W-1:0];
                        div0_q[0]  <= (dvsr_q == '0);
                        state_q    <= DIV_SKIP;
                        step_q     <= '0;
                        rem_q      <= '0;
                        dq_q       <= num_skip;
                        dvsr_q     <= skip_cnt_q;
                    end
                end
                DIV_SKIP: begin
                    rem_q  <= rem_d;
                    dq_q   <= dq_d;
                    step_q <= step_q + 1'b1;
                    if (step_q == STEP_LAST) begin
                        rate_skip_q  <= (dvsr_q == '0) ? '0 : dq_d[PCT_W-1:0];
                        div0_q[1]    <= (dvsr_q == '0);
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        rate_valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign halt_rise       = halt_rise_q;
    assign branch_inst_cnt = branch_cnt_q;
    assign flush_cnt       = flush_cnt_q;
    assign skip_en_cnt     = skip_cnt_q;
    assign skip_flush_cnt  = skip_flush_cnt_q;
    assign rate_all        = rate_all_q;
    assign rate_skip       = rate_skip_q;
    assign rate_valid      = rate_valid_q;
    assign div0            = div0_q;
    assign busy            = busy_q;

endmodule
